trace_capture_ctrl: RTL and testbench

//  Capture controller that sits in front of ram_1c_1r_1w. It writes a circular
//  pre-trigger history of probe samples into the RAM write port, then a fixed

---
 rtl/trace_capture_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_trace_capture_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl
// Capture controller in front of a 1-clock RAM with one read port and one
// write port. It keeps a circular pre-trigger history in the RAM. After the
// trigger it stores a fixed post-trigger window. It then drains all Depth
// entries, oldest first, as a ready/valid stream through a 2-entry buffer.
// No RAM read is issued while a write is possible, so the two ports never
// collide.
module trace_capture_ctrl #(
    parameter int Width    = 18,
    parameter int Depth    = 64,
    parameter int PostTrig = 32,
    localparam int AddrBits = $clog2(Depth)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic                smp_valid,
    input  logic [Width-1:0]    smp_data,
    input  logic                trig,
    output logic                ram_wr_en,
    output logic [AddrBits-1:0] ram_wr_addr,
    output logic [Width-1:0]    ram_wr_data,
    output logic [AddrBits-1:0] ram_rd_addr,
    input  logic [Width-1:0]    ram_rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Width-1:0]    out_data,
    output logic                out_last,
    output logic                busy,
    output logic                triggered,
    output logic                done
);

    localparam int CntBits = $clog2(Depth + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_POST = 2'd2;
    localparam logic [1:0] S_READ = 2'd3;

    localparam logic [CntBits-1:0]  PreLen   = CntBits'(Depth - PostTrig);
    localparam logic [CntBits-1:0]  PostLen  = CntBits'(PostTrig);
    localparam logic [CntBits-1:0]  DepthCnt = CntBits'(Depth);
    localparam logic [AddrBits-1:0] AddrMax  = AddrBits'(Depth - 1);

    logic [1:0]          state_q, state_d;
    logic [AddrBits-1:0] wptr_q, wptr_d;
    logic [AddrBits-1:0] rptr_q, rptr_d;
    logic [CntBits-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CntBits-1:0]  post_cnt_q, post_cnt_d;
    logic [CntBits-1:0]  rd_cnt_q, rd_cnt_d;
    logic                triggered_q, triggered_d;

    // Readout pipeline: one RAM read in flight plus a 2-entry output buffer.
    logic                pend_q, pend_d;
    logic                pend_last_q, pend_last_d;
    logic [1:0]          count_q, count_d;
    logic                head_q, head_d;
    logic [Width-1:0]    buf_data_q [2];
    logic                buf_last_q [2];

    logic                wr_fire;
    logic                trig_accept;
    logic                pop;
    logic                rd_issue;
    logic                final_pop;
    logic                tail;
    logic [2:0]          occ;
    logic [AddrBits-1:0] wptr_inc;
    logic [AddrBits-1:0] rptr_inc;

    // Handshake and pipeline-credit terms shared by the next-state logic.
    always_comb begin
        wr_fire     = smp_valid && (state_q == S_PRE || state_q == S_POST);
        trig_accept = (state_q == S_PRE) && smp_valid && trig && (pre_cnt_q >= PreLen);
        pop         = (count_q != 2'd0) && out_ready;
        // Buffer slots already committed after this cycle's pop. A new read
        // is issued only if its data is sure to find a free slot.
        occ         = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
        rd_issue    = (state_q == S_READ) && (rd_cnt_q != DepthCnt) && (occ < 3'd2);
        final_pop   = (state_q == S_READ) && pop && buf_last_q[head_q];
        tail        = head_q ^ count_q[0];
        wptr_inc    = (wptr_q == AddrMax) ? '0 : wptr_q + 1'b1;
        rptr_inc    = (rptr_q == AddrMax) ? '0 : rptr_q + 1'b1;
    end

    // Next-state logic for the capture FSM, pointers and readout bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        triggered_d = triggered_q;
        pend_d      = rd_issue;
        pend_last_d = rd_issue && (rd_cnt_q == DepthCnt - 1'b1);
        count_d     = count_q + {1'b0, pend_q} - {1'b0, pop};
        head_d      = head_q ^ pop;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d    = S_PRE;
                    wptr_d     = '0;
                    pre_cnt_d  = '0;
                    post_cnt_d = '0;
                end
            end
            S_PRE: begin
                if (wr_fire) begin
                    wptr_d = wptr_inc;
                    if (pre_cnt_q != PreLen) pre_cnt_d = pre_cnt_q + 1'b1;
                end
                // The trigger sample is written in this cycle and counts as
                // post sample 1.
                if (trig_accept) begin
                    triggered_d = 1'b1;
                    post_cnt_d  = CntBits'(1);
                    state_d     = (PostTrig == 1) ? S_READ : S_POST;
                end
            end
            S_POST: begin
                if (wr_fire) begin
                    wptr_d     = wptr_inc;
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_q + 1'b1 == PostLen) state_d = S_READ;
                end
            end
            S_READ: begin
                if (rd_issue) begin
                    rptr_d   = rptr_inc;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (final_pop) begin
                    state_d     = S_IDLE;
                    triggered_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The RAM is always full when the capture ends, so the next write
        // slot holds the oldest sample.
        if (state_q != S_READ && state_d == S_READ) begin
            rptr_d   = wptr_d;
            rd_cnt_d = '0;
        end

        // Abort overrides everything: the in-flight read and the buffer are
        // discarded.
        if (abort) begin
            state_d     = S_IDLE;
            triggered_d = 1'b0;
            count_d     = 2'd0;
            head_d      = 1'b0;
            pend_d      = 1'b0;
            pend_last_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            triggered_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            count_q     <= 2'd0;
            head_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that
            // every register samples the pre-edge values.
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            triggered_q <= triggered_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            count_q     <= count_d;
            head_q      <= head_d;
        end
    end

    // Output buffer: RAM data lands in the tail slot one cycle after its read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this two-entry buffer drives out_data directly, so it is
            // reset so that every output reads zero during reset. The large
            // capture RAM is left unreset.
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
        end else if (pend_q && !abort) begin
            buf_data_q[tail] <= ram_rd_data;
            buf_last_q[tail] <= pend_last_q;
        end
    end

    assign ram_wr_en   = wr_fire;
    assign ram_wr_addr = wptr_q;
    assign ram_wr_data = smp_data;
    assign ram_rd_addr = rptr_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_data    = buf_data_q[head_q];
    assign out_last    = out_valid && buf_last_q[head_q];
    assign busy        = (state_q != S_IDLE);
    assign triggered   = triggered_q;
    assign done        = final_pop && !abort;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl (Depth=8, PostTrig=3).
// It contains a behavioural RAM and a queue-based model of the captured
// window. The window is computed as "the last Depth samples written, ending
// PostTrig samples after the first acceptable trigger".
module tb_trace_capture_ctrl;

    localparam int Width    = 18;
    localparam int Depth    = 8;
    localparam int PostTrig = 3;
    localparam int AddrBits = 3;
    localparam int PreLen   = Depth - PostTrig;

    logic                clk, rst_n;
    logic                arm, abort, smp_valid, trig, out_ready;
    logic [Width-1:0]    smp_data;
    logic                ram_wr_en;
    logic [AddrBits-1:0] ram_wr_addr, ram_rd_addr;
    logic [Width-1:0]    ram_wr_data, ram_rd_data, out_data;
    logic                out_valid, out_last, busy, triggered, done;

    trace_capture_ctrl #(.Width(Width), .Depth(Depth), .PostTrig(PostTrig)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .smp_valid(smp_valid), .smp_data(smp_data), .trig(trig),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .triggered(triggered), .done(done)
    );

    // Behavioural 1-clock RAM: read data is valid one cycle after the address.
    logic [Width-1:0] ram_mem [Depth];
    always_ff @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= ram_mem[ram_rd_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got=timeout need=finish");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;
    int viol_stable = 0;
    int viol_rw     = 0;
    bit stall_q = 1'b0;
    bit abort_prev = 1'b0;
    logic [Width-1:0] stall_data;
    logic stall_last;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d need=%0d", name, act, exp);
        end
    endtask

    // Let combinational outputs settle after new inputs; check stall stability.
    task automatic settle();
        #1;
        if (stall_q && !abort_prev) begin
            if (!out_valid || out_data != stall_data || out_last != stall_last) viol_stable++;
        end
        stall_q    = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
        abort_prev = abort;
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full capture with the model running alongside.
    // mode: 1 = strobe every cycle, 3 = every 3rd cycle, 0 = random strobes.
    // abort_mode: 0 none, 1 during POST, 2 during READ with out_valid.
    task automatic run_capture(input string name, input logic [63:0] mask, input int mode,
                               input bit rnd_ready, input int abort_mode, input int first_exp);
        logic [Width-1:0] q_written[$];
        logic [Width-1:0] got[$];
        int  nsamp = 0, post = 0, sidx = 0, k = 0, first_k = -1;
        int  gaps = 0, dones = 0, last_bad = 0, wr_bad = 0, st_bad = 0, errs = 0;
        bit  trig_seen = 0, cap_done = 0, finished = 0, aborted = 0, strobe;

        arm = 1'b1;
        settle();
        advance();
        arm = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            strobe    = (mode == 0) ? ($urandom_range(0, 9) < 6) : (cyc % mode == 0);
            smp_valid = strobe;
            smp_data  = (strobe && mode != 0) ? Width'(sidx) : Width'($urandom);
            trig      = strobe ? (sidx < 64 && mask[sidx]) : 1'($urandom_range(0, 1));
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            abort     = ((abort_mode == 1) && trig_seen && !cap_done) ||
                        ((abort_mode == 2) && cap_done && out_valid);
            settle();

            if (ram_wr_en != (strobe && !cap_done)) wr_bad++;
            if (ram_wr_en && ram_wr_data != smp_data) wr_bad++;
            if (ram_wr_en && ram_wr_addr != AddrBits'(nsamp % Depth)) wr_bad++;
            if (ram_wr_en && (cap_done || out_valid)) viol_rw++;
            if (triggered != trig_seen || !busy) st_bad++;
            if (cap_done) begin
                k++;
                if (out_valid && first_k < 0) first_k = k;
            end
            if (first_k > 0 && !rnd_ready && !out_valid) gaps++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (out_last != (got.size() == Depth)) last_bad++;
            end
            if (done) begin
                dones++;
                if (!(out_valid && out_ready && out_last)) last_bad++;
                finished = 1;
            end

            if (!abort && strobe && !cap_done) begin
                q_written.push_back(smp_data);
                if (!trig_seen) begin
                    if (trig && nsamp >= PreLen) begin
                        trig_seen = 1;
                        post      = 1;
                    end
                end else begin
                    post++;
                end
                nsamp++;
                if (trig_seen && post == PostTrig) cap_done = 1;
            end
            if (strobe) sidx++;
            advance();
            if (abort) begin
                abort   = 1'b0;
                aborted = 1;
                break;
            end
        end
        smp_valid = 1'b0;
        trig      = 1'b0;
        out_ready = 1'b1;
        settle();
        check({name, "_wr_path"}, wr_bad, 0);
        check({name, "_busy_trig"}, st_bad, 0);
        check({name, "_idle_after"}, busy, 0);
        check({name, "_trig_clear"}, triggered, 0);
        if (aborted) begin
            check({name, "_abort_valid"}, out_valid, 0);
            for (int i = 0; i < 3; i++) begin
                if (done) dones++;
                advance();
                settle();
            end
            check({name, "_no_done"}, dones, 0);
        end else begin
            check({name, "_finished"}, finished, 1);
            check({name, "_count"}, got.size(), Depth);
            for (int i = 0; i < got.size() && i < Depth && q_written.size() >= Depth; i++) begin
                if (got[i] != q_written[q_written.size() - Depth + i]) errs++;
            end
            check({name, "_order"}, errs, 0);
            check({name, "_last"}, last_bad, 0);
            check({name, "_done_once"}, dones, 1);
            check({name, "_first_valid_in_time"}, (first_k > 0 && first_k <= 3), 1);
            if (!rnd_ready) check({name, "_no_gaps"}, gaps, 0);
            if (first_exp >= 0 && got.size() == Depth) begin
                check({name, "_first_sample"}, got[0], first_exp);
                check({name, "_final_sample"}, got[Depth-1], first_exp + Depth - 1);
            end
        end
    endtask

    typedef struct {
        logic             arm, abort, smp_valid, trig;
        logic [Width-1:0] data;
        logic             exp_wr_en, exp_busy, exp_trig;
        int               exp_addr;  // -1 = don't care
    } vec_t;

    vec_t vecs[10];
    logic [63:0] m;
    bit seen;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 18'd7,   1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 18'd100, 1'b1, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 18'd101, 1'b1, 1'b1, 1'b0, 1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 18'd0,   1'b0, 1'b1, 1'b0, 2};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 18'd102, 1'b1, 1'b1, 1'b0, 2};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 18'd103, 1'b0, 1'b0, 1'b0, -1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0, 1'b0, -1};

        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; smp_valid = 1'b0; trig = 1'b0;
        smp_data = '0; out_ready = 1'b0;
        #2;
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_triggered", triggered, 0);
        check("reset_done", done, 0);
        check("reset_wr_addr", ram_wr_addr, 0);
        check("reset_rd_addr", ram_rd_addr, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle control vectors: arm/abort priority, trigger qualification.
        for (int i = 0; i < 10; i++) begin
            arm = vecs[i].arm; abort = vecs[i].abort; smp_valid = vecs[i].smp_valid;
            trig = vecs[i].trig; smp_data = vecs[i].data;
            settle();
            check($sformatf("vec%0d_wr_en", i), ram_wr_en, vecs[i].exp_wr_en);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_triggered", i), triggered, vecs[i].exp_trig);
            if (vecs[i].exp_addr >= 0) check($sformatf("vec%0d_wr_addr", i), ram_wr_addr, vecs[i].exp_addr);
            if (vecs[i].exp_wr_en) check($sformatf("vec%0d_wr_data", i), ram_wr_data, vecs[i].data);
            advance();
        end
        arm = 1'b0; abort = 1'b0; smp_valid = 1'b0; trig = 1'b0;
        advance();

        run_capture("c1_basic", 64'h400, 1, 1'b0, 0, 5);
        run_capture("c2_early_trig", 64'h2e, 1, 1'b0, 0, 0);
        run_capture("c3_rand_ready", 64'h400, 1, 1'b1, 0, 5);
        run_capture("c4_sparse", 64'h400, 3, 1'b0, 0, 5);
        run_capture("c5_abort_post", 64'h400, 1, 1'b0, 1, -1);
        run_capture("c5_abort_read", 64'h400, 1, 1'b1, 2, -1);
        run_capture("c5_rearm", 64'h400, 1, 1'b0, 0, 5);
        for (int r = 0; r < 6; r++) begin
            m = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
            m[20] = 1'b1;
            run_capture($sformatf("rnd%0d", r), m, 0, 1'($urandom_range(0, 1)), 0, -1);
        end

        // Asynchronous reset in the middle of readout.
        arm = 1'b1;
        settle();
        advance();
        arm  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            smp_valid = 1'b1; smp_data = Width'(i); trig = (i == 10); out_ready = 1'b0;
            settle();
            if (out_valid) seen = 1'b1;
            else advance();
        end
        check("rst_reached_read", seen, 1);
        smp_valid = 1'b0; trig = 1'b0; smp_data = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
        check("rst_wr_addr", ram_wr_addr, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        stall_q = 1'b0;
        run_capture("post_reset", 64'h400, 1, 1'b0, 0, 5);

        check("no_write_during_read", viol_rw, 0);
        check("data_stable_while_stalled", viol_stable, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
